// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate-unit self-test sequencer.
// The truth table packs vector k = {a,b} at bits [7k+6:7k].
package gate_sweep_pkg;

  localparam int NUM_VEC = 4;
  localparam int RES_W   = 7;
  localparam int TT_W    = NUM_VEC * RES_W;

  localparam int AND_B  = 6;
  localparam int NAND_B = 5;
  localparam int OR_B   = 4;
  localparam int NOR_B  = 3;
  localparam int XOR_B  = 2;
  localparam int XNOR_B = 1;
  localparam int NOT_B  = 0;

  // Expected {and,nand,or,nor,xor,xnor,not} per vector, vector 3 in the MSBs.
  localparam logic [TT_W-1:0] GOLDEN_TT = {7'h52, 7'h34, 7'h35, 7'h2B};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } sweep_state_e;

  function automatic logic [RES_W-1:0] tt_vec(input logic [TT_W-1:0] tt,
                                              input logic [1:0]      k);
    return tt[int'(k) * RES_W +: RES_W];
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: cleared while not settling, counts up while enabled and
// flags the last settle cycle so the sequencer can move on to capture.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps a/b through all four input pairs, captures the
// seven gate outputs per vector and grades the table against golden values.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [RES_W-1:0] gate_res,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RES_W-1:0] fail_mask,
  output logic [TT_W-1:0]  truth_table
);

  sweep_state_e     state_q;
  sweep_state_e     state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [TT_W-1:0]  tt_q;
  logic [TT_W-1:0]  tt_d;
  logic [RES_W-1:0] mask_q;
  logic [RES_W-1:0] mask_d;
  logic             pass_q;
  logic             pass_d;
  logic [RES_W-1:0] mismatch;
  logic             settle_clear;
  logic             settle_en;
  logic             settle_tc;

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (settle_clear),
    .enable (settle_en),
    .tc     (settle_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort is only meaningful once a sweep is running; DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)          state_d = ST_IDLE;
        else if (settle_tc) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)               state_d = ST_IDLE;
        else if (idx_q == 2'd3)  state_d = ST_CHECK;
        else                     state_d = ST_SETTLE;
      end
      ST_CHECK: begin
        if (abort) state_d = ST_IDLE;
        else       state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    gate_a       = 1'b0;
    gate_b       = 1'b0;
    settle_en    = 1'b0;
    settle_clear = 1'b1;
    unique case (state_q)
      ST_SETTLE: begin
        busy         = 1'b1;
        gate_a       = idx_q[1];
        gate_b       = idx_q[0];
        settle_en    = 1'b1;
        settle_clear = 1'b0;
      end
      ST_CAPTURE, ST_CHECK: begin
        busy   = 1'b1;
        gate_a = idx_q[1];
        gate_b = idx_q[0];
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mismatch = '0;
    for (int k = 0; k < NUM_VEC; k++) begin
      mismatch = mismatch | (tt_vec(tt_q, 2'(k)) ^ tt_vec(GOLDEN_TT, 2'(k)));
    end
  end

  // An abort freezes the captured table and leaves the verdict cleared.
  always_comb begin
    idx_d  = idx_q;
    tt_d   = tt_q;
    mask_d = mask_q;
    pass_d = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = 2'd0;
          tt_d   = '0;
          mask_d = '0;
          pass_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort) idx_d = 2'd0;
      end
      ST_CAPTURE: begin
        if (abort) begin
          idx_d = 2'd0;
        end else begin
          for (int k = 0; k < NUM_VEC; k++) begin
            if (idx_q == 2'(k)) tt_d[k*RES_W +: RES_W] = gate_res;
          end
          if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          idx_d = 2'd0;
        end else begin
          mask_d = mismatch;
          pass_d = (mismatch == '0);
        end
      end
      ST_DONE: idx_d = 2'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 2'd0;
      tt_q   <= '0;
      mask_q <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      tt_q   <= tt_d;
      mask_q <= mask_d;
      pass_q <= pass_d;
    end
  end

  assign pass        = pass_q;
  assign fail_mask   = mask_q;
  assign truth_table = tt_q;

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-test sequencer for the two-input logic gate unit (outputs and, nand, or, nor, xor, xnor, not).
- On a start pulse it drives the gate inputs a/b through all four combinations (00, 01, 10, 11) and waits a programmable settle time per vector.
- It captures all seven gate outputs into a truth-table register, then compares the table against golden values and reports pass/fail with a per-function mismatch mask.
- It sits between a test/host controller and the combinational gate unit, replacing hand-written stimulus sequences.

Parameters:
- SETTLE_CYCLES, 2, cycles gate inputs are held before capture; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  cancels a running sweep.
- gate_res  input  7  gate unit outputs {and,nand,or,nor,xor,xnor,not}, bit 6 = and, bit 0 = not (not = ~a).
- gate_a  output  1  drive to gate input a.
- gate_b  output  1  drive to gate input b.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse when results are valid.
- pass  output  1  1 if all 28 captured bits match golden; held until next start.
- fail_mask  output  7  bit set if that function mismatched on any vector; same bit order as gate_res.
- truth_table  output  28  captured results; vector k = {a,b} is stored at [7k+6:7k].

Behaviour:
- Reset, and idle after reset:
  - gate_a = 0, gate_b = 0, busy = 0, done = 0, pass = 0.
  - fail_mask = 0, truth_table = 0.
  - Internal vector index = 0, settle counter = 0, state = IDLE.
- States: IDLE, SETTLE, CAPTURE, CHECK, DONE.
- IDLE:
  - start = 1 → gate_a/gate_b ← 0/0, idx ← 0, cnt ← 0, truth_table ← 0, fail_mask ← 0, pass ← 0, go to SETTLE.
- SETTLE:
  - busy = 1, cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE:
  - truth_table[idx] ← gate_res.
  - If idx == 3, go to CHECK.
  - Otherwise idx ← idx+1, {gate_a,gate_b} ← idx+1, cnt ← 0, go to SETTLE.
- CHECK:
  - Compare against golden: vector 0 = 7'h2B, vector 1 = 7'h35, vector 2 = 7'h34, vector 3 = 7'h52.
  - fail_mask ← OR over vectors of (captured XOR golden).
  - pass ← (mask == 0).
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, gate_a/gate_b return to 0, go to IDLE.
- Latency:
  - Sweep takes 4*(SETTLE_CYCLES+1) cycles in SETTLE/CAPTURE, then 1 in CHECK.
  - done rises 4*(SETTLE_CYCLES+1)+1 clock edges after the edge that samples start (13 for default).
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start in the DONE cycle: ignored.
  - abort in any non-IDLE state: next state IDLE, busy = 0, done not pulsed, gate_a/gate_b = 0. pass and fail_mask stay 0; truth_table keeps the partial capture.
  - abort and start in the same cycle in IDLE: start wins, abort has no effect in IDLE.
  - rst mid-sweep: all outputs return to their reset values on the next edge, regardless of other inputs.
  - gate_res is sampled only in CAPTURE; values in other states are don't-care.
  - Index arithmetic is 2-bit with no wrap past 3; CHECK is entered instead.

Decomposition:
- Package gate_sweep_pkg:
  - state enum.
  - Bit-index constants AND_B = 6 … NOT_B = 0.
  - GOLDEN_TT = 28'h{52,34,35,2B} packed, vector 3 in the MSBs.
  - NUM_VEC = 4, RES_W = 7.
- One natural sub-module: sweep_settle_timer.
  - Loadable CNT_W counter with clear, enable and terminal-count flag at SETTLE_CYCLES-1.
- The gate unit itself stays outside; the bench or top level connects gate_a/gate_b/gate_res.

Test Plan:
- Golden sweep: correct gate model connected, SETTLE_CYCLES = 2, pulse start → gate inputs step 00, 01, 10, 11 every 3 cycles; done at edge 13; pass = 1; fail_mask = 0; truth_table = 28'h{52,34,35,2B}.
- Stuck-at fault: force the xor output to 0 → vectors 01/10 capture 7'h31/7'h30; pass = 0; fail_mask = 7'b0000100.
- Inverted not: model not as ~b → mismatches on vectors 01 and 10; fail_mask = 7'b0000001; pass = 0.
- abort after the second CAPTURE → next cycle busy = 0, no done pulse, gate_a = gate_b = 0; a following start runs a full sweep and passes.
- start pulsed again at cycles 3 and 8 of a running sweep → ignored; single done at edge 13; pass = 1.
- rst asserted mid-SETTLE of vector 2 → next edge all outputs at reset values, state IDLE; SETTLE_CYCLES = 1 rerun gives done at edge 9 with pass = 1.
